if_stage: RTL and testbench

Instruction fetch stage. It sits directly upstream of the ctrl decoder and feeds it an instruction word and its PC.
- Owns the fetch PC.
- Issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers up to DEPTH instructions.
- Presents them to decode with a valid/ready handshake.
- Flushes on a jump/branch redirect from execute.

---
 rtl/if_stage_pkg.sv | 34 +++
 rtl/if_inst_buf.sv | 62 ++++++
 rtl/if_stage.sv | 75 +++++++
 tb/tb_if_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Fetch-stage constants, slot record and PC helpers shared by if_stage and its buffer.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef PC_STEP
`define PC_STEP 4
`endif

package if_stage_pkg;
  localparam int INST_WIDTH = `INST_WIDTH;
  localparam int PC_WIDTH   = `PC_WIDTH;
  localparam logic [INST_WIDTH-1:0] INST_NOP = `INST_NOP;
  localparam logic [PC_WIDTH-1:0]   PC_STEP  = PC_WIDTH'(`PC_STEP);

  // Requests squashed by repeated redirects can pile up in memory, so this is wider than DEPTH needs.
  localparam int DISC_W = 8;

  typedef struct packed {
    logic                  valid;
    logic                  filled;
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] ir;
  } slot_t;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_inst_buf.sv
// In-order instruction buffer: slots are allocated at grant time and filled as responses return.
module if_inst_buf
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alloc,
  input  logic [PC_WIDTH-1:0]   alloc_pc,
  input  logic                  fill,
  input  logic [INST_WIDTH-1:0] fill_ir,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [PC_WIDTH-1:0]   head_pc,
  output logic [INST_WIDTH-1:0] head_ir,
  output logic [PTR_W:0]        filled_count
);
  slot_t            slots [DEPTH];
  slot_t            head;
  logic [PTR_W:0]   alloc_ptr, fill_ptr, head_ptr;
  logic [PTR_W-1:0] alloc_idx, fill_idx, head_idx;

  assign alloc_idx = alloc_ptr[PTR_W-1:0];
  assign fill_idx  = fill_ptr[PTR_W-1:0];
  assign head_idx  = head_ptr[PTR_W-1:0];

  assign head         = slots[head_idx];
  assign head_valid   = head.valid && head.filled;
  assign head_pc      = head_valid ? head.pc : '0;
  assign head_ir      = head_valid ? head.ir : INST_NOP;
  assign filled_count = fill_ptr - head_ptr;

  // Alloc is written last so a full buffer can reuse the slot being popped in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '{valid: 1'b0, filled: 1'b0, pc: '0, ir: INST_NOP};
      end
    end else begin
      if (pop) begin
        slots[head_idx].valid  <= 1'b0;
        slots[head_idx].filled <= 1'b0;
        head_ptr <= head_ptr + (PTR_W+1)'(1);
      end
      if (fill) begin
        slots[fill_idx].filled <= 1'b1;
        slots[fill_idx].ir     <= fill_ir;
        fill_ptr <= fill_ptr + (PTR_W+1)'(1);
      end
      if (alloc) begin
        slots[alloc_idx] <= '{valid: 1'b1, filled: 1'b0, pc: alloc_pc, ir: INST_NOP};
        alloc_ptr <= alloc_ptr + (PTR_W+1)'(1);
      end
    end
  end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests and feeds decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int                  DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [INST_WIDTH-1:0] id_ir,
  output logic [PC_WIDTH-1:0]   id_pc
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [CNT_W-1:0]    outstanding;
  logic [CNT_W-1:0]    filled_count;
  logic [DISC_W-1:0]   discard;
  logic [CNT_W:0]      slots_used;
  logic                fire, rsp_drop, rsp_fill, pop;

  assign rsp_drop = imem_rvalid && (discard != '0);
  assign rsp_fill = imem_rvalid && (discard == '0) && (outstanding != '0);
  assign pop      = id_valid && id_ready && !redirect_valid;

  // Filled slots plus outstanding requests equals allocated slots; a pop hands its slot to this grant.
  assign slots_used = {1'b0, filled_count} + {1'b0, outstanding} - {{CNT_W{1'b0}}, pop};
  assign imem_req   = rst_n && !redirect_valid && (slots_used < (CNT_W+1)'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign fire       = imem_req && imem_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= align_pc(redirect_pc);
      outstanding <= '0;
      discard     <= discard - DISC_W'(rsp_drop) + DISC_W'(outstanding) - DISC_W'(rsp_fill);
    end else begin
      if (fire) fetch_pc <= fetch_pc + PC_STEP;
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(rsp_fill);
      discard     <= discard - DISC_W'(rsp_drop);
    end
  end

  if_inst_buf #(.DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (redirect_valid),
    .alloc        (fire),
    .alloc_pc     (fetch_pc),
    .fill         (rsp_fill),
    .fill_ir      (imem_rdata),
    .pop          (pop),
    .head_valid   (id_valid),
    .head_pc      (id_pc),
    .head_ir      (id_ir),
    .filled_count (filled_count)
  );

  // A response nobody asked for is dropped; flag it so the memory side gets fixed.
  unexpected_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (discard == '0) && (outstanding == '0)));
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, then randomized memory/decode/redirect traffic.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_ir, id_pc;

  logic        w_req, w_gnt, w_rvalid, w_valid;
  logic        w_redir = 1'b0;
  logic        w_ready = 1'b1;
  logic [31:0] w_addr, w_rdata, w_ir, w_pc;
  logic [31:0] w_rpc = 32'h0;

  if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_pc(id_pc));

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .id_valid(w_valid), .id_ready(w_ready), .id_ir(w_ir), .id_pc(w_pc));

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit gnt; bit rdy; bit redir; logic [31:0] rpc; int lat;
    bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
  } vec_t;
  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; int cyc; } arr_t;

  vec_t        tbl [$];
  mreq_t       mem_q [$];
  arr_t        ready_q [$];
  logic [31:0] w_seen [$];
  int          cyc, epoch, n_cmp, n_bad;
  logic [31:0] exp_pc, exp_fetch, w_pend_addr;
  bit          w_pend;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ XMASK;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit gnt, input bit rdy, input bit redir,
                     input logic [31:0] rpc, input int lat, input bit er,
                     input logic [31:0] ea, input bit ev, input logic [31:0] ep);
    tbl.push_back('{rst: rst, gnt: gnt, rdy: rdy, redir: redir, rpc: rpc, lat: lat,
                    e_req: er, e_addr: ea, e_valid: ev, e_pc: ep});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
    mem_q.delete(); ready_q.delete(); w_pend = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_ir", id_ir, NOP);
    chk("rst_pc", id_pc, 32'h0);
    rst_n = 1'b1;
    epoch++;
    exp_pc = 32'h0;
    exp_fetch = 32'h0;
  endtask

  // Model: decode must see consecutive PCs from the last reset/redirect target; an instruction
  // becomes visible the cycle after its live response, and fetched-but-undelivered words never exceed DEPTH.
  task automatic step(input vec_t v, input bit directed, input bit rv_en);
    bit    rv, e_valid, e_req, popn;
    int    used;
    mreq_t m;
    rv = rv_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_gnt = v.gnt; id_ready = v.rdy; redirect_valid = v.redir; redirect_pc = v.rpc;
    imem_rvalid = rv;
    imem_rdata = rv ? data_of(mem_q[0].addr) : 32'hDEAD_BEEF;
    w_gnt = 1'b1; w_rvalid = w_pend; w_rdata = data_of(w_pend_addr);
    #1;
    e_valid = (ready_q.size() > 0) && (ready_q[0].cyc < cyc);
    chk("id_valid", 32'(id_valid), 32'(e_valid));
    if (e_valid) begin
      chk("id_pc", id_pc, exp_pc);
      chk("id_ir", id_ir, data_of(exp_pc));
    end
    popn  = e_valid && v.rdy && !v.redir;
    used  = int'((exp_fetch - exp_pc) >> 2) - int'(popn);
    e_req = !v.redir && (used < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, exp_fetch);
    if (directed) begin
      chk("t_req", 32'(imem_req), 32'(v.e_req));
      chk("t_addr", imem_addr, v.e_addr);
      chk("t_valid", 32'(id_valid), 32'(v.e_valid));
      if (v.e_valid) chk("t_pc", id_pc, v.e_pc);
    end
    if (w_valid) begin
      chk("wrap_ir", w_ir, data_of(w_pc));
      if (w_seen.size() < 3) w_seen.push_back(w_pc);
    end

    if (popn) begin
      void'(ready_q.pop_front());
      exp_pc += 32'd4;
    end
    if (rv) begin
      m = mem_q.pop_front();
      if (m.epoch == epoch && !v.redir) ready_q.push_back('{pc: m.addr, cyc: cyc});
    end
    if (e_req && v.gnt) begin
      mem_q.push_back('{addr: exp_fetch, due: cyc + v.lat, epoch: epoch});
      exp_fetch += 32'd4;
    end
    if (v.redir) begin
      epoch++;
      ready_q.delete();
      exp_pc = {v.rpc[31:2], 2'b00};
      exp_fetch = exp_pc;
    end
    w_pend = w_req;
    w_pend_addr = w_addr;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] wrap_exp [3];
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
    n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0;

    // streaming
    add(1,1,1,0,0,1, 1,32'h00, 0,0);
    add(0,1,1,0,0,1, 1,32'h04, 0,0);
    add(0,1,1,0,0,1, 1,32'h08, 1,32'h0);
    add(0,1,1,0,0,1, 1,32'h0C, 1,32'h4);
    add(0,1,1,0,0,1, 1,32'h10, 1,32'h8);
    add(0,1,1,0,0,1, 1,32'h14, 1,32'hC);
    // backpressure then release
    add(1,1,0,0,0,1, 1,32'h00, 0,0);
    add(0,1,0,0,0,1, 1,32'h04, 0,0);
    add(0,1,0,0,0,1, 0,32'h08, 1,32'h0);
    add(0,1,0,0,0,1, 0,32'h08, 1,32'h0);
    add(0,1,0,0,0,1, 0,32'h08, 1,32'h0);
    add(0,1,1,0,0,1, 1,32'h08, 1,32'h0);
    add(0,1,1,0,0,1, 1,32'h0C, 1,32'h4);
    add(0,1,1,0,0,1, 1,32'h10, 1,32'h8);
    add(0,1,1,0,0,1, 1,32'h14, 1,32'hC);
    // grant stall at 0x8
    add(1,1,1,0,0,1, 1,32'h00, 0,0);
    add(0,1,1,0,0,1, 1,32'h04, 0,0);
    add(0,0,1,0,0,1, 1,32'h08, 1,32'h0);
    add(0,0,1,0,0,1, 1,32'h08, 1,32'h4);
    add(0,0,1,0,0,1, 1,32'h08, 0,0);
    add(0,1,1,0,0,1, 1,32'h08, 0,0);
    add(0,1,1,0,0,1, 1,32'h0C, 0,0);
    add(0,1,1,0,0,1, 1,32'h10, 1,32'h8);
    // redirect with two requests in flight
    add(1,1,1,0,0,3, 1,32'h00, 0,0);
    add(0,1,1,0,0,3, 1,32'h04, 0,0);
    add(0,1,1,1,32'h103,1, 0,32'h08, 0,0);
    add(0,1,1,0,0,1, 1,32'h100, 0,0);
    add(0,1,1,0,0,1, 1,32'h104, 0,0);
    add(0,1,1,0,0,1, 0,32'h108, 0,0);
    add(0,1,1,0,0,1, 1,32'h108, 1,32'h100);
    add(0,1,1,0,0,1, 1,32'h10C, 1,32'h104);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i], 1'b1, 1'b1);
    end

    chk("wrap_count", 32'(w_seen.size()), 32'd3);
    for (int i = 0; i < 3 && i < w_seen.size(); i++) chk("wrap_pc", w_seen[i], wrap_exp[i]);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      v.rst   = 1'b0;
      v.gnt   = ($urandom_range(0, 3) != 0);
      v.rdy   = ($urandom_range(0, 3) != 0);
      v.redir = ($urandom_range(0, 24) == 0);
      v.rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      v.lat   = $urandom_range(1, 4);
      v.e_req = 1'b0; v.e_addr = '0; v.e_valid = 1'b0; v.e_pc = '0;
      step(v, 1'b0, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
